// File: rtl/pattern_count_engine.sv
// Pattern-count accelerator: counts a 5-bit pattern in a byte message (in-byte, per-byte, sliding).
// Optional busy output enabled by defining PAT_BUSY_OUT_EN.
module pattern_count_engine #(
  parameter int NUM_BYTES = 32,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
`ifdef PAT_BUSY_OUT_EN
  output logic              busy,
`endif
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  localparam int DEPTH = NUM_BYTES + 4;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [4:0]          pat_q;
  logic [7:0]          ctb_q, cto_q, cts_q;
  logic [7:0]          ctb_d, cto_d, cts_d;
  logic                done_q;
  logic [7:0]          mem_q [DEPTH];

  logic                last;
  logic [11:0]         win;
  logic [2:0]          inb_cnt, cross_cnt;

  assign last = (idx_q == LAST_IDX);
  // Current byte followed by the top nibble of the next one; at the last byte
  // that nibble comes from the pattern slot and is masked out of the count.
  assign win  = {mem_q[idx_q], mem_q[idx_q + 1'b1][7:4]};

  always_comb begin
    inb_cnt   = '0;
    cross_cnt = '0;
    for (int unsigned p = 0; p < 8; p++) begin
      if (win[11-p -: 5] == pat_q) begin
        if (p < 4)      inb_cnt   = inb_cnt + 3'd1;
        else if (!last) cross_cnt = cross_cnt + 3'd1;
      end
    end
    ctb_d = ctb_q + 8'(inb_cnt);
    cto_d = cto_q + 8'(inb_cnt != 3'd0);
    cts_d = cts_q + 8'(inb_cnt) + 8'(cross_cnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pat_q   <= '0;
      ctb_q   <= '0;
      cto_q   <= '0;
      cts_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= SCAN;
            idx_q   <= '0;
            pat_q   <= mem_q[NUM_BYTES][7:3];
            ctb_q   <= '0;
            cto_q   <= '0;
            cts_q   <= '0;
            done_q  <= 1'b0;
          end else if (state_q == DONE) begin
            done_q  <= 1'b1;
          end
        end
        SCAN: begin
          ctb_q <= ctb_d;
          cto_q <= cto_d;
          cts_q <= cts_d;
          if (last) state_q <= WRITE;
          else      idx_q   <= idx_q + 1'b1;
        end
        WRITE:   state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Message memory is deliberately not reset so results survive an aborted scan.
  always_ff @(posedge clk) begin
    if (state_q == WRITE) begin
      mem_q[NUM_BYTES+1] <= ctb_q;
      mem_q[NUM_BYTES+2] <= cto_q;
      mem_q[NUM_BYTES+3] <= cts_q;
    end else if (wr_en && (state_q == IDLE || state_q == DONE) &&
                 ({1'b0, wr_addr} < DEPTH_W)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = ({1'b0, rd_addr} < DEPTH_W) ? mem_q[rd_addr] : '0;
  assign done    = done_q;

`ifdef PAT_BUSY_OUT_EN
  assign busy = (state_q == SCAN) || (state_q == WRITE) || (state_q == DONE && !done_q);
`endif

endmodule

// File: tb/tb_pattern_count_engine.sv
// Directed self-checking bench for pattern_count_engine (default 32-byte message).
module tb_pattern_count_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
`ifdef PAT_BUSY_OUT_EN
  logic       busy;
`endif
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] msg_m [32];

  pattern_count_engine #(.NUM_BYTES(32), .ADDR_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .done    (done),
`ifdef PAT_BUSY_OUT_EN
    .busy    (busy),
`endif
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  // Reference counts from the flat bit string of msg_m.
  function automatic logic [23:0] model(input logic [4:0] p);
    logic [255:0] bits;
    int ctb, cto, cts, nb;
    logic [4:0] w;
    ctb = 0; cto = 0; cts = 0;
    for (int i = 0; i < 256; i++) bits[i] = msg_m[i/8][7 - (i % 8)];
    for (int s = 0; s <= 251; s++) begin
      w = {bits[s], bits[s+1], bits[s+2], bits[s+3], bits[s+4]};
      if (w == p) cts++;
    end
    for (int b = 0; b < 32; b++) begin
      nb = 0;
      for (int k = 0; k < 4; k++) begin
        w = {bits[8*b+k], bits[8*b+k+1], bits[8*b+k+2], bits[8*b+k+3], bits[8*b+k+4]};
        if (w == p) nb++;
      end
      ctb += nb;
      if (nb != 0) cto++;
    end
    return {8'(ctb), 8'(cto), 8'(cts)};
  endfunction

  task automatic wr_byte(input logic [5:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load_msg();
    for (int i = 0; i < 32; i++) wr_byte(6'(i), msg_m[i]);
  endtask

  task automatic rd_byte(input logic [5:0] a, output logic [7:0] d);
    rd_addr = a; #1; d = rd_data;
  endtask

  task automatic run_start(output int lat, output logic done_after);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_after = done;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_results(input string name, input logic [7:0] eb, input logic [7:0] eo, input logic [7:0] es);
    logic [7:0] v;
    rd_byte(6'd33, v); checks++;
    if (v !== eb) begin errors++; $display("FAIL %s CTB got %0d exp %0d", name, v, eb); end
    rd_byte(6'd34, v); checks++;
    if (v !== eo) begin errors++; $display("FAIL %s CTO got %0d exp %0d", name, v, eo); end
    rd_byte(6'd35, v); checks++;
    if (v !== es) begin errors++; $display("FAIL %s CTS got %0d exp %0d", name, v, es); end
  endtask

  task automatic check_lat(input string name, input int lat, input logic da);
    checks++;
    if (da !== 1'b0) begin errors++; $display("FAIL %s done_after_start got %b exp 0", name, da); end
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL %s latency got %0d exp 34", name, lat); end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
`ifdef PAT_BUSY_OUT_EN
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
`endif
    rd_byte(6'd40, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL rd_oob got %h exp 00", v); end
  endtask

  task automatic test_alternating();
    int lat; logic da;
    for (int i = 0; i < 32; i++) msg_m[i] = 8'h55;
    load_msg();
    wr_byte(6'd32, 8'hA8);
    run_start(lat, da);
    check_lat("alt", lat, da);
    check_results("alt", 8'd64, 8'd32, 8'd126);
  endtask

  task automatic test_zeros();
    int lat; logic da;
    for (int i = 0; i < 32; i++) msg_m[i] = 8'h00;
    load_msg();
    wr_byte(6'd32, 8'h00);
    run_start(lat, da);
    check_lat("zeros", lat, da);
    check_results("zeros", 8'd128, 8'd32, 8'd252);
  endtask

  task automatic test_cross_byte();
    int lat; logic da;
    wr_byte(6'd0, 8'h07);
    wr_byte(6'd1, 8'hC0);
    wr_byte(6'd32, 8'hF8);
    run_start(lat, da);
    check_lat("cross", lat, da);
    check_results("cross", 8'd0, 8'd0, 8'd1);
  endtask

  task automatic test_pattern_low_bits();
    int lat; logic da;
    logic [23:0] exp;
    for (int i = 0; i < 32; i++) msg_m[i] = 8'((i * 37 + 29) ^ (i << 3));
    load_msg();
    exp = model(5'b10110);
    wr_byte(6'd32, 8'hB0);
    run_start(lat, da);
    check_lat("lowbits_b0", lat, da);
    check_results("lowbits_b0", exp[23:16], exp[15:8], exp[7:0]);
    wr_byte(6'd32, 8'hB7);
    run_start(lat, da);
    check_lat("lowbits_b7", lat, da);
    check_results("lowbits_b7", exp[23:16], exp[15:8], exp[7:0]);
  endtask

  task automatic test_reset_abort();
    int lat; logic da;
    logic [7:0] v;
    for (int i = 0; i < 32; i++) msg_m[i] = 8'h55;
    load_msg();
    wr_byte(6'd32, 8'hA8);
    wr_byte(6'd33, 8'h11);
    wr_byte(6'd34, 8'h11);
    wr_byte(6'd35, 8'h11);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin start = 1'b1; wr_en = 1'b1; wr_addr = 6'd0; wr_data = 8'h00; end
      if (c == 4) begin start = 1'b0; wr_addr = 6'd33; wr_data = 8'hEE; end
      if (c == 5) wr_en = 1'b0;
      @(posedge clk); #1;
    end
    reset = 1'b0; #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done); end
    check_results("abort", 8'h11, 8'h11, 8'h11);
    rd_byte(6'd0, v); checks++;
    if (v !== 8'h55) begin errors++; $display("FAIL abort_msg0 got %h exp 55", v); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_start(lat, da);
    check_lat("restart", lat, da);
    check_results("restart", 8'd64, 8'd32, 8'd126);
  endtask

  task automatic test_back_to_back();
    int lat; logic da;
    wr_byte(6'd32, 8'h00);
    run_start(lat, da);
    check_lat("b2b", lat, da);
    check_results("b2b", 8'd0, 8'd0, 8'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    test_alternating();
    test_zeros();
    test_cross_byte();
    test_pattern_low_bits();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
